// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo traffic-light family: lamp codes,
// controller state encoding and default phase lengths.
package semaforo_pkg;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_OFF    = 3'b000;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_FLASH  = 2'd3
  } state_t;

  localparam int DEF_T_GREEN  = 1;
  localparam int DEF_T_YELLOW = 3;
  localparam int DEF_T_ALLRED = 2;
  localparam int DEF_T_FLASH  = 2;

endpackage

// File: rtl/semaforo_rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping,
// with 'last' itself scanned at the end. Zero latency; next is 'last' when no hit.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] next,
  output logic             hit
);

  logic found;

  always_comb begin
    next  = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        next  = IDX_W'((int'(last) + k) % N);
        found = 1'b1;
      end
    end
    hit = found;
  end

endmodule

// File: rtl/semaforo_multi.sv
// N-approach traffic-light controller: green/yellow/all-red rotation steered by
// latched demand, plus flashing-yellow maintenance mode. Moore lamp outputs, no backpressure.
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter int               N_APPR   = 2,
  parameter int               CNT_W    = 8,
  parameter logic [CNT_W-1:0] T_GREEN  = CNT_W'(DEF_T_GREEN),
  parameter logic [CNT_W-1:0] T_YELLOW = CNT_W'(DEF_T_YELLOW),
  parameter logic [CNT_W-1:0] T_ALLRED = CNT_W'(DEF_T_ALLRED),
  parameter logic [CNT_W-1:0] T_FLASH  = CNT_W'(DEF_T_FLASH),
  parameter int               IDX_W    = $clog2(N_APPR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_APPR-1:0]   bt,
  input  logic                flash,
  output logic [3*N_APPR-1:0] lights,
  output logic [IDX_W-1:0]    green_idx,
  output logic [N_APPR-1:0]   pending
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               blink, blink_n;
  logic [N_APPR-1:0]  pending_n;
  logic               enter_green;
  logic [IDX_W-1:0]   pick_next;
  logic               pick_hit;
  logic [IDX_W-1:0]   idx_inc;
  logic [N_APPR-1:0]  serve_mask;
  logic [N_APPR-1:0]  clr_mask;
  logic [2:0]         lamp;

  rr_pick #(
    .N     (N_APPR),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (pending),
    .last (idx),
    .next (pick_next),
    .hit  (pick_hit)
  );

  assign idx_inc = (idx == IDX_W'(N_APPR - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_ALLRED;
      cnt     <= T_ALLRED - 1'b1;
      idx     <= IDX_W'(N_APPR - 1);
      blink   <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      blink   <= blink_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt - 1'b1;
    idx_n       = idx;
    blink_n     = blink;
    enter_green = 1'b0;
    if (flash) begin
      // Maintenance request overrides any phase; once in FLASH just keep blinking.
      state_n = S_FLASH;
      if (state != S_FLASH) begin
        blink_n = 1'b1;
        cnt_n   = T_FLASH - 1'b1;
      end else if (cnt == '0) begin
        blink_n = ~blink;
        cnt_n   = T_FLASH - 1'b1;
      end
    end else begin
      case (state)
        S_GREEN: begin
          if (cnt == '0) begin
            state_n = S_YELLOW;
            cnt_n   = T_YELLOW - 1'b1;
          end
        end
        S_YELLOW: begin
          if (cnt == '0) begin
            state_n = S_ALLRED;
            cnt_n   = T_ALLRED - 1'b1;
          end
        end
        S_ALLRED: begin
          if (cnt == '0) begin
            state_n     = S_GREEN;
            cnt_n       = T_GREEN - 1'b1;
            idx_n       = pick_hit ? pick_next : idx_inc;
            enter_green = 1'b1;
          end
        end
        S_FLASH: begin
          state_n = S_ALLRED;
          cnt_n   = T_ALLRED - 1'b1;
          blink_n = 1'b0;
        end
        default: begin
          state_n = S_ALLRED;
          cnt_n   = T_ALLRED - 1'b1;
        end
      endcase
    end
  end

  // The approach being served cannot queue a request against itself; the green
  // entry edge clears its own bit even if bt is high on that edge.
  always_comb begin
    serve_mask = '0;
    clr_mask   = '0;
    if (state == S_GREEN || state == S_YELLOW) begin
      serve_mask = N_APPR'(1) << idx;
    end
    if (enter_green) begin
      clr_mask = N_APPR'(1) << idx_n;
    end
    pending_n = (pending | (bt & ~serve_mask)) & ~clr_mask;
  end

  always_comb begin
    lights = '0;
    lamp   = LT_RED;
    for (int i = 0; i < N_APPR; i++) begin
      lamp = LT_RED;
      case (state)
        S_GREEN:  lamp = (IDX_W'(i) == idx) ? LT_GREEN : LT_RED;
        S_YELLOW: lamp = (IDX_W'(i) == idx) ? LT_YELLOW : LT_RED;
        S_ALLRED: lamp = LT_RED;
        S_FLASH:  lamp = blink ? LT_YELLOW : LT_OFF;
        default:  lamp = LT_RED;
      endcase
      lights[3*i +: 3] = lamp;
    end
  end

  assign green_idx = idx;

endmodule

// File: tb/tb_semaforo_multi.sv
// Directed bench for semaforo_multi: a 2-approach and a 4-approach instance,
// expected lamp/pending/index values queued per cycle and compared after each edge.
module tb_semaforo_multi;
  import semaforo_pkg::*;

  typedef struct {
    logic [11:0] l;
    logic [11:0] p;
    logic [11:0] g;
    string       tag;
  } exp_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] bt_a;
  logic [3:0] bt_b;
  logic       flash_a, flash_b;
  logic [5:0] lights_a;
  logic [11:0] lights_b;
  logic [0:0] gidx_a;
  logic [1:0] gidx_b;
  logic [1:0] pend_a;
  logic [3:0] pend_b;

  int checks = 0;
  int failures = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  semaforo_multi #(.N_APPR(2)) dut_a (
    .clk(clk), .rst(rst_a), .bt(bt_a), .flash(flash_a),
    .lights(lights_a), .green_idx(gidx_a), .pending(pend_a)
  );

  semaforo_multi #(.N_APPR(4)) dut_b (
    .clk(clk), .rst(rst_b), .bt(bt_b), .flash(flash_b),
    .lights(lights_b), .green_idx(gidx_b), .pending(pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Approach i shows code c, every other approach of n shows red.
  function automatic logic [11:0] one(input int n, input int i, input logic [2:0] c);
    logic [11:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[3*j +: 3] = (j == i) ? c : LT_RED;
    return r;
  endfunction

  function automatic logic [11:0] all(input int n, input logic [2:0] c);
    logic [11:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[3*j +: 3] = c;
    return r;
  endfunction

  task automatic ea(input logic [11:0] l, input int p, input int g, input string tag);
    exp_t e;
    e.l = l; e.p = 12'(p); e.g = 12'(g); e.tag = tag;
    sb_a.push_back(e);
  endtask

  task automatic eb(input logic [11:0] l, input int p, input int g, input string tag);
    exp_t e;
    e.l = l; e.p = 12'(p); e.g = 12'(g); e.tag = tag;
    sb_b.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      cmp({e.tag, "/lights"}, {6'b0, lights_a}, e.l);
      cmp({e.tag, "/pending"}, {10'b0, pend_a}, e.p);
      cmp({e.tag, "/gidx"}, {11'b0, gidx_a}, e.g);
    end
    while (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      cmp({e.tag, "/lights"}, lights_b, e.l);
      cmp({e.tag, "/pending"}, {8'b0, pend_b}, e.p);
      cmp({e.tag, "/gidx"}, {10'b0, gidx_b}, e.g);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bt_a = '0; bt_b = '0;
    flash_a = 1'b0; flash_b = 1'b0;

    // N=2 reset and default sequence
    ea(all(2, LT_RED), 0, 1, "a_reset"); step();
    rst_a = 1'b1;
    ea(all(2, LT_RED), 0, 1, "a_allred2"); step();
    ea(one(2, 0, LT_GREEN), 0, 0, "a_g0"); step();
    repeat (3) begin ea(one(2, 0, LT_YELLOW), 0, 0, "a_y0"); step(); end
    repeat (2) begin ea(all(2, LT_RED), 0, 0, "a_r"); step(); end
    bt_a = 2'b10;
    ea(one(2, 1, LT_GREEN), 0, 1, "a_same_edge"); step();
    bt_a = '0;
    ea(one(2, 1, LT_YELLOW), 0, 1, "a_y1"); step();

    // N=4 demand skip
    rst_b = 1'b1;
    eb(all(4, LT_RED), 0, 3, "b_start"); step();
    eb(one(4, 0, LT_GREEN), 0, 0, "b_g0"); step();
    bt_b = 4'b0100;
    eb(one(4, 0, LT_YELLOW), 4, 0, "b_req2"); step();
    bt_b = '0;
    repeat (2) begin eb(one(4, 0, LT_YELLOW), 4, 0, "b_y0"); step(); end
    repeat (2) begin eb(all(4, LT_RED), 4, 0, "b_r_pend"); step(); end
    eb(one(4, 2, LT_GREEN), 0, 2, "b_skip_g2"); step();
    repeat (3) begin eb(one(4, 2, LT_YELLOW), 0, 2, "b_y2"); step(); end
    repeat (2) begin eb(all(4, LT_RED), 0, 2, "b_r2"); step(); end
    eb(one(4, 3, LT_GREEN), 0, 3, "b_g3"); step();
    repeat (3) begin eb(one(4, 3, LT_YELLOW), 0, 3, "b_y3"); step(); end

    // Tie and wrap from idx=3 with pending 1001
    eb(all(4, LT_RED), 0, 3, "b_r3a"); step();
    bt_b = 4'b1001;
    eb(all(4, LT_RED), 9, 3, "b_tie_pend"); step();
    bt_b = '0;
    eb(one(4, 0, LT_GREEN), 8, 0, "b_wrap_g0"); step();
    repeat (3) begin eb(one(4, 0, LT_YELLOW), 8, 0, "b_y0b"); step(); end
    repeat (2) begin eb(all(4, LT_RED), 8, 0, "b_r0b"); step(); end
    eb(one(4, 3, LT_GREEN), 0, 3, "b_g3b"); step();
    eb(one(4, 3, LT_YELLOW), 0, 3, "b_y3b"); step();

    // Flash mid-yellow, then resume from kept idx
    flash_b = 1'b1;
    repeat (2) begin eb(all(4, LT_YELLOW), 0, 3, "b_flash_on"); step(); end
    repeat (2) begin eb(all(4, LT_OFF), 0, 3, "b_flash_off"); step(); end
    repeat (2) begin eb(all(4, LT_YELLOW), 0, 3, "b_flash_on2"); step(); end
    flash_b = 1'b0;
    repeat (2) begin eb(all(4, LT_RED), 0, 3, "b_flash_clear"); step(); end
    bt_b = 4'b0010;
    eb(one(4, 0, LT_GREEN), 2, 0, "b_resume_g0"); step();
    bt_b = '0;

    // Mid-green reset with pending set, flash raised at the same time
    rst_b = 1'b0; flash_b = 1'b1;
    eb(all(4, LT_RED), 0, 3, "b_midrst"); step();
    rst_b = 1'b1; flash_b = 1'b0;
    eb(all(4, LT_RED), 0, 3, "b_rst_r2"); step();
    eb(one(4, 0, LT_GREEN), 0, 0, "b_rst_g0"); step();
    repeat (3) begin eb(one(4, 0, LT_YELLOW), 0, 0, "b_rst_y0"); step(); end
    repeat (2) begin eb(all(4, LT_RED), 0, 0, "b_rst_r"); step(); end
    eb(one(4, 1, LT_GREEN), 0, 1, "b_rst_g1"); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
